// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit 7-segment time display: active-low fonts,
// digit-index and view-mode encodings, and the tens/ones digit split.
package fnd_pkg;

   localparam logic [7:0] FONT_0     = 8'hC0;
   localparam logic [7:0] FONT_1     = 8'hF9;
   localparam logic [7:0] FONT_2     = 8'hA4;
   localparam logic [7:0] FONT_3     = 8'hB0;
   localparam logic [7:0] FONT_4     = 8'h99;
   localparam logic [7:0] FONT_5     = 8'h92;
   localparam logic [7:0] FONT_6     = 8'h82;
   localparam logic [7:0] FONT_7     = 8'hF8;
   localparam logic [7:0] FONT_8     = 8'h80;
   localparam logic [7:0] FONT_9     = 8'h90;
   localparam logic [7:0] FONT_DASH  = 8'hBF;
   localparam logic [7:0] FONT_BLANK = 8'hFF;

   localparam logic [3:0] CODE_DASH  = 4'd10;

   localparam logic [1:0] IDX_0 = 2'd0;
   localparam logic [1:0] IDX_1 = 2'd1;
   localparam logic [1:0] IDX_2 = 2'd2;
   localparam logic [1:0] IDX_3 = 2'd3;

   localparam logic MODE_HHMM = 1'b0;
   localparam logic MODE_SSCC = 1'b1;

   // Values above 99 cannot be shown in two digits and map to the dash code.
   function automatic logic [3:0] split_digit(input logic [6:0] v, input logic tens);
      logic [3:0] code;
      if (v > 7'd99) begin
         code = CODE_DASH;
      end else if (tens) begin
         code = 4'(v / 7'd10);
      end else begin
         code = 4'(v % 7'd10);
      end
      return code;
   endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational digit-code to active-low segment pattern, with optional
// decimal point (bit 7 cleared when dp_i is set).
module fnd_font_decoder
   import fnd_pkg::*;
(
   input  logic [3:0] code_i,
   input  logic       dp_i,
   output logic [7:0] font_o
);

   logic [7:0] base_s;

   // Digit glyph lookup; unknown codes render blank.
   always_comb begin
      base_s = FONT_BLANK;
      case (code_i)
         4'd0:    base_s = FONT_0;
         4'd1:    base_s = FONT_1;
         4'd2:    base_s = FONT_2;
         4'd3:    base_s = FONT_3;
         4'd4:    base_s = FONT_4;
         4'd5:    base_s = FONT_5;
         4'd6:    base_s = FONT_6;
         4'd7:    base_s = FONT_7;
         4'd8:    base_s = FONT_8;
         4'd9:    base_s = FONT_9;
         4'd10:   base_s = FONT_DASH;
         default: base_s = FONT_BLANK;
      endcase
   end

   assign font_o = base_s & {~dp_i, 7'h7F};

endmodule

// File: rtl/fnd_time_display.sv
// Time-multiplexed 4-digit common-anode display driver showing HH.MM or SS.CC
// from a per-frame snapshot of the time fields.
module fnd_time_display
   import fnd_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1_000
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [5:0] i_hour,
   input  logic [5:0] i_min,
   input  logic [5:0] i_sec,
   input  logic [6:0] i_msec,
   input  logic       i_mode_sel,
   output logic [3:0] o_fnd_com,
   output logic [7:0] o_fnd_font
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 2) begin : g_div_check
      $error("fnd_time_display: CLK_HZ/SCAN_HZ must be at least 2");
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          primed_q;
   logic [5:0]    snap_hour_q, snap_min_q, snap_sec_q;
   logic [6:0]    snap_msec_q;
   logic          snap_mode_q;
   logic [3:0]    com_q, com_d;
   logic [7:0]    font_q, font_d;

   logic          tick_s;
   logic          snap_load_s;
   logic [6:0]    sel_val_s;
   logic          sel_tens_s;
   logic          dp_s;
   logic [3:0]    code_s;
   logic [7:0]    dec_font_s;

   assign tick_s      = (cnt_q == CW'(DIV - 1));
   assign snap_load_s = ~primed_q | (tick_s & (idx_q == IDX_3));

   // Prescaler and digit-index advance.
   always_comb begin
      if (tick_s) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
         idx_d = idx_q;
      end
   end

   // Select which snapshot field and digit feed the current index.
   always_comb begin
      sel_val_s  = 7'd0;
      sel_tens_s = 1'b0;
      dp_s       = 1'b0;
      case ({snap_mode_q, idx_q})
         {MODE_HHMM, IDX_0}: begin sel_val_s = {1'b0, snap_min_q};  sel_tens_s = 1'b0; end
         {MODE_HHMM, IDX_1}: begin sel_val_s = {1'b0, snap_min_q};  sel_tens_s = 1'b1; end
         {MODE_HHMM, IDX_2}: begin
            sel_val_s  = {1'b0, snap_hour_q};
            sel_tens_s = 1'b0;
            dp_s       = (snap_msec_q < 7'd50);
         end
         {MODE_HHMM, IDX_3}: begin sel_val_s = {1'b0, snap_hour_q}; sel_tens_s = 1'b1; end
         {MODE_SSCC, IDX_0}: begin sel_val_s = snap_msec_q;         sel_tens_s = 1'b0; end
         {MODE_SSCC, IDX_1}: begin sel_val_s = snap_msec_q;         sel_tens_s = 1'b1; end
         {MODE_SSCC, IDX_2}: begin
            sel_val_s  = {1'b0, snap_sec_q};
            sel_tens_s = 1'b0;
            dp_s       = 1'b1;
         end
         {MODE_SSCC, IDX_3}: begin sel_val_s = {1'b0, snap_sec_q};  sel_tens_s = 1'b1; end
         default: begin sel_val_s = 7'd0; sel_tens_s = 1'b0; dp_s = 1'b0; end
      endcase
   end

   assign code_s = split_digit(sel_val_s, sel_tens_s);

   fnd_font_decoder u_font_decoder (
      .code_i (code_s),
      .dp_i   (dp_s),
      .font_o (dec_font_s)
   );

   // Keep the display dark until the first snapshot has been captured.
   always_comb begin
      if (primed_q) begin
         com_d  = ~(4'b0001 << idx_q);
         font_d = dec_font_s;
      end else begin
         com_d  = 4'b1111;
         font_d = FONT_BLANK;
      end
   end

   // Scan counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q    <= '0;
         idx_q    <= IDX_0;
         primed_q <= 1'b0;
         com_q    <= 4'b1111;
         font_q   <= FONT_BLANK;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         primed_q <= 1'b1;
         com_q    <= com_d;
         font_q   <= font_d;
      end
   end

   // Frame snapshot: captured once after reset and at every frame wrap.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         snap_hour_q <= 6'd0;
         snap_min_q  <= 6'd0;
         snap_sec_q  <= 6'd0;
         snap_msec_q <= 7'd0;
         snap_mode_q <= MODE_HHMM;
      end else if (snap_load_s) begin
         snap_hour_q <= i_hour;
         snap_min_q  <= i_min;
         snap_sec_q  <= i_sec;
         snap_msec_q <= i_msec;
         snap_mode_q <= i_mode_sel;
      end else begin
         snap_hour_q <= snap_hour_q;
         snap_min_q  <= snap_min_q;
         snap_sec_q  <= snap_sec_q;
         snap_msec_q <= snap_msec_q;
         snap_mode_q <= snap_mode_q;
      end
   end

   assign o_fnd_com  = com_q;
   assign o_fnd_font = font_q;

endmodule

// File: tb/tb_fnd_time_display.sv
// Directed self-checking bench for fnd_time_display with DIV = 4.
module tb_fnd_time_display;

   logic       i_clk;
   logic       i_reset_n;
   logic [5:0] i_hour;
   logic [5:0] i_min;
   logic [5:0] i_sec;
   logic [6:0] i_msec;
   logic       i_mode_sel;
   logic [3:0] o_fnd_com;
   logic [7:0] o_fnd_font;

   int pass_cnt;
   int total_cnt;

   logic [3:0] cap_com  [16];
   logic [7:0] cap_font [16];
   logic [3:0] com_seq  [4];

   fnd_time_display #(
      .CLK_HZ  (1000),
      .SCAN_HZ (250)
   ) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_hour     (i_hour),
      .i_min      (i_min),
      .i_sec      (i_sec),
      .i_msec     (i_msec),
      .i_mode_sel (i_mode_sel),
      .o_fnd_com  (o_fnd_com),
      .o_fnd_font (o_fnd_font)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance to the first negedge where com freshly becomes 1110 (start of a frame).
   task automatic sync_frame();
      logic [3:0] prev;
      bit found;
      prev  = o_fnd_com;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         @(negedge i_clk);
         if (o_fnd_com == 4'b1110 && prev != 4'b1110) found = 1'b1;
         prev = o_fnd_com;
      end
      if (!found) begin
         total_cnt++;
         $display("FAIL sync_frame: com=%b, required a fresh 1110 within 40 cycles", o_fnd_com);
      end
   endtask

   // Record one full frame starting at the current negedge.
   task automatic capture_frame();
      for (int k = 0; k < 16; k++) begin
         cap_com[k]  = o_fnd_com;
         cap_font[k] = o_fnd_font;
         @(negedge i_clk);
      end
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      repeat (3) @(negedge i_clk);
      total_cnt++;
      if (o_fnd_com !== 4'b1111 || o_fnd_font !== 8'hFF)
         $display("FAIL reset_hold: com=%b font=%h, required 1111/FF", o_fnd_com, o_fnd_font);
      else pass_cnt++;
      i_reset_n = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      total_cnt++;
      if (o_fnd_com !== 4'b1110 || o_fnd_font !== 8'h99)
         $display("FAIL reset_first_digit: com=%b font=%h, required 1110/99", o_fnd_com, o_fnd_font);
      else pass_cnt++;
      repeat (5) @(negedge i_clk);
      #2 i_reset_n = 1'b0;
      #1;
      total_cnt++;
      if (o_fnd_com !== 4'b1111 || o_fnd_font !== 8'hFF)
         $display("FAIL reset_async: com=%b font=%h, required 1111/FF", o_fnd_com, o_fnd_font);
      else pass_cnt++;
      @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   task automatic test_mode0();
      logic [7:0] exp_font [4];
      exp_font[0] = 8'h99; exp_font[1] = 8'hB0; exp_font[2] = 8'h24; exp_font[3] = 8'hF9;
      sync_frame();
      sync_frame();
      capture_frame();
      for (int k = 0; k < 16; k++) begin
         total_cnt++;
         if (cap_com[k] !== com_seq[k/4] || cap_font[k] !== exp_font[k/4])
            $display("FAIL mode0[%0d]: com=%b font=%h, required %b/%h",
                     k, cap_com[k], cap_font[k], com_seq[k/4], exp_font[k/4]);
         else pass_cnt++;
      end
      i_msec = 7'd60;
      sync_frame();
      sync_frame();
      capture_frame();
      for (int k = 8; k < 12; k++) begin
         total_cnt++;
         if (cap_com[k] !== 4'b1011 || cap_font[k] !== 8'hA4)
            $display("FAIL mode0_dp_off[%0d]: com=%b font=%h, required 1011/a4", k, cap_com[k], cap_font[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_mode1();
      logic [7:0] exp_font [4];
      exp_font[0] = 8'hF8; exp_font[1] = 8'hC0; exp_font[2] = 8'h12; exp_font[3] = 8'hC0;
      i_mode_sel = 1'b1;
      i_sec      = 6'd5;
      i_msec     = 7'd7;
      sync_frame();
      sync_frame();
      capture_frame();
      for (int k = 0; k < 16; k++) begin
         total_cnt++;
         if (cap_com[k] !== com_seq[k/4] || cap_font[k] !== exp_font[k/4])
            $display("FAIL mode1[%0d]: com=%b font=%h, required %b/%h",
                     k, cap_com[k], cap_font[k], com_seq[k/4], exp_font[k/4]);
         else pass_cnt++;
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0] exp_font [4];
      exp_font[0] = 8'hBF; exp_font[1] = 8'hBF; exp_font[2] = 8'h30; exp_font[3] = 8'hA4;
      i_mode_sel = 1'b1;
      i_sec      = 6'd23;
      i_msec     = 7'd127;
      sync_frame();
      sync_frame();
      capture_frame();
      for (int k = 0; k < 16; k += 2) begin
         total_cnt++;
         if (cap_com[k] !== com_seq[k/4] || cap_font[k] !== exp_font[k/4])
            $display("FAIL out_of_range[%0d]: com=%b font=%h, required %b/%h",
                     k, cap_com[k], cap_font[k], com_seq[k/4], exp_font[k/4]);
         else pass_cnt++;
      end
   endtask

   task automatic test_tear_free();
      logic [7:0] old_font [4];
      logic [7:0] new_font [4];
      logic [7:0] ef;
      old_font[0] = 8'h99; old_font[1] = 8'hB0; old_font[2] = 8'h24; old_font[3] = 8'hF9;
      new_font[0] = 8'hA4; new_font[1] = 8'h99; new_font[2] = 8'h10; new_font[3] = 8'h92;
      i_mode_sel = 1'b0;
      i_hour     = 6'd12;
      i_min      = 6'd34;
      i_sec      = 6'd59;
      i_msec     = 7'd10;
      sync_frame();
      sync_frame();
      repeat (4) @(negedge i_clk);
      total_cnt++;
      if (o_fnd_com !== 4'b1101)
         $display("FAIL tear_position: com=%b, required 1101", o_fnd_com);
      else pass_cnt++;
      i_hour     = 6'd7;
      i_min      = 6'd8;
      i_msec     = 7'd42;
      i_mode_sel = 1'b1;
      for (int k = 5; k < 32; k++) begin
         @(negedge i_clk);
         ef = (k < 16) ? old_font[k/4] : new_font[(k-16)/4];
         total_cnt++;
         if (o_fnd_com !== com_seq[(k/4)%4] || o_fnd_font !== ef)
            $display("FAIL tear_free[%0d]: com=%b font=%h, required %b/%h",
                     k, o_fnd_com, o_fnd_font, com_seq[(k/4)%4], ef);
         else pass_cnt++;
      end
   endtask

   task automatic test_scan_timing();
      logic [3:0] prev;
      int run;
      int seen;
      int pos;
      sync_frame();
      prev = o_fnd_com;
      run  = 1;
      seen = 0;
      pos  = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge i_clk);
         total_cnt++;
         if (o_fnd_com !== 4'b1110 && o_fnd_com !== 4'b1101 &&
             o_fnd_com !== 4'b1011 && o_fnd_com !== 4'b0111)
            $display("FAIL scan_onehot[%0d]: com=%b, required a single low bit", n, o_fnd_com);
         else pass_cnt++;
         if (o_fnd_com !== prev) begin
            pos = (pos + 1) % 4;
            total_cnt++;
            if (run !== 4 || o_fnd_com !== com_seq[pos])
               $display("FAIL scan_step[%0d]: run=%0d com=%b, required run 4 com %b",
                        seen, run, o_fnd_com, com_seq[pos]);
            else pass_cnt++;
            seen++;
            run = 1;
         end else begin
            run++;
         end
         prev = o_fnd_com;
      end
      total_cnt++;
      if (seen < 9)
         $display("FAIL scan_transitions: saw %0d transitions, required at least 9", seen);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      com_seq[0] = 4'b1110;
      com_seq[1] = 4'b1101;
      com_seq[2] = 4'b1011;
      com_seq[3] = 4'b0111;
      i_reset_n  = 1'b0;
      i_hour     = 6'd12;
      i_min      = 6'd34;
      i_sec      = 6'd0;
      i_msec     = 7'd10;
      i_mode_sel = 1'b0;

      test_reset();
      test_mode0();
      test_mode1();
      test_out_of_range();
      test_tear_free();
      test_scan_timing();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
